// File: rtl/it_boot_loader_pkg.sv
// it_boot_loader_pkg: shared configuration for the IT RAM boot loader.
//   XLEN          address/data width
//   BOOT_IT_ADDR  IT RAM base address (boot fetch address)
//   IT_RAM_DEPTH  IT RAM capacity in 32-bit words
//   store_size_e  write_size encodings (NO_STORE / STORE_WORD used here)
package it_boot_loader_pkg;

  localparam int unsigned     XLEN         = 32;
  localparam logic [XLEN-1:0] BOOT_IT_ADDR = 32'h0000_0000;
  localparam int unsigned     IT_RAM_DEPTH = 1024;

  typedef enum logic [1:0] {
    NO_STORE   = 2'b00,
    STORE_BYTE = 2'b01,
    STORE_HALF = 2'b10,
    STORE_WORD = 2'b11
  } store_size_e;

  // Word index must also hold the value MEM_DEPTH itself (the word count).
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/it_byte_assembler.sv
// it_byte_assembler: 4-byte little-endian word assembler.
//   clk, rst   clock, asynchronous active-low reset
//   clear      drop any partial word and restart at byte 0
//   shift      a byte is accepted this cycle
//   byte_in    the accepted byte
//   word       assembled word including byte_in (meaningful with word_valid)
//   word_valid this shift completes a word (counter wraps 3->0)
module it_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  // The current byte is folded in combinationally so the consumer sees the
  // complete word on the same edge that accepts the fourth byte.
  assign word       = {byte_in, shreg};
  assign word_valid = shift && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= word[31:8];
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/it_boot_loader.sv
// it_boot_loader: fills IT RAM from a byte stream, then releases the core.
// Frame: 4-byte LE word count N, then N LE words; optional 4-byte LE
// checksum (sum of data words) when IT_BOOT_CKSUM_EN is defined.
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_data    byte stream; in_ready accepts (LEN/DATA/CKSUM only)
//   boot_start          re-arms from DONE or ERROR
//   write_flag/addr/data/size  IT RAM write port, one strobe per word
//   cpu_hold            core stall, low only in DONE
//   boot_done/boot_err  load complete / sticky error
module it_boot_loader #(
  parameter int unsigned     XLEN      = it_boot_loader_pkg::XLEN,
  parameter logic [XLEN-1:0] MEM_BASE  = it_boot_loader_pkg::BOOT_IT_ADDR,
  parameter int unsigned     MEM_DEPTH = it_boot_loader_pkg::IT_RAM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic            boot_start,
  output logic            write_flag,
  output logic [XLEN-1:0] write_addr,
  output logic [31:0]     write_data,
  output logic [1:0]      write_size,
  output logic            cpu_hold,
  output logic            boot_done,
  output logic            boot_err
);

  import it_boot_loader_pkg::*;

  localparam int unsigned IDX_W = idx_width(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
`ifdef IT_BOOT_CKSUM_EN
    , ST_CKSUM
`endif
  } state_e;

  state_e           state;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] n_words;
  logic [IDX_W-1:0] idx_next;
  logic [31:0]      asm_word;
  logic             asm_valid;
  logic             accept;
  logic             rearm;
`ifdef IT_BOOT_CKSUM_EN
  logic [31:0]      sum;
`endif

  assign accept   = in_valid && in_ready;
  assign rearm    = boot_start && ((state == ST_DONE) || (state == ST_ERROR));
  assign idx_next = word_idx + IDX_W'(1);

  it_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (rearm),
    .shift      (accept),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_LEN;
      word_idx   <= '0;
      n_words    <= '0;
      in_ready   <= 1'b1;
      write_flag <= 1'b0;
      write_addr <= MEM_BASE;
      write_data <= '0;
      write_size <= NO_STORE;
      cpu_hold   <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
`ifdef IT_BOOT_CKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        ST_LEN: begin
          if (asm_valid) begin
            if (asm_word == '0) begin
`ifdef IT_BOOT_CKSUM_EN
              state     <= ST_CKSUM;
`else
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              cpu_hold  <= 1'b0;
              boot_done <= 1'b1;
`endif
            end else if (asm_word > 32'(MEM_DEPTH)) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              boot_err <= 1'b1;
            end else begin
              // Range already checked, so the truncation is lossless.
              n_words <= asm_word[IDX_W-1:0];
              state   <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (asm_valid) begin
            state      <= ST_WRITE;
            in_ready   <= 1'b0;
            write_flag <= 1'b1;
            write_size <= STORE_WORD;
            write_addr <= MEM_BASE + XLEN'({word_idx, 2'b00});
            write_data <= asm_word;
`ifdef IT_BOOT_CKSUM_EN
            sum        <= sum + asm_word;
`endif
          end
        end

        ST_WRITE: begin
          write_flag <= 1'b0;
          write_size <= NO_STORE;
          word_idx   <= idx_next;
          if (idx_next == n_words) begin
`ifdef IT_BOOT_CKSUM_EN
            state     <= ST_CKSUM;
            in_ready  <= 1'b1;
`else
            state     <= ST_DONE;
            cpu_hold  <= 1'b0;
            boot_done <= 1'b1;
`endif
          end else begin
            state    <= ST_DATA;
            in_ready <= 1'b1;
          end
        end

`ifdef IT_BOOT_CKSUM_EN
        ST_CKSUM: begin
          if (asm_valid) begin
            in_ready <= 1'b0;
            if (asm_word == sum) begin
              state     <= ST_DONE;
              cpu_hold  <= 1'b0;
              boot_done <= 1'b1;
            end else begin
              state    <= ST_ERROR;
              boot_err <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          if (boot_start) begin
            state     <= ST_LEN;
            word_idx  <= '0;
            n_words   <= '0;
            in_ready  <= 1'b1;
            cpu_hold  <= 1'b1;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
`ifdef IT_BOOT_CKSUM_EN
            sum       <= '0;
`endif
          end
        end

        default: state <= ST_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_it_boot_loader.sv
`timescale 1ns/1ps
module tb_it_boot_loader;
  import it_boot_loader_pkg::*;

  localparam logic [31:0] TB_BASE  = 32'h0001_0000;
  localparam int unsigned TB_DEPTH = 1024;
`ifdef IT_BOOT_CKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        boot_start = 1'b0;
  logic        in_ready, write_flag, cpu_hold, boot_done, boot_err;
  logic [31:0] write_addr, write_data;
  logic [1:0]  write_size;

  always #5 clk = ~clk;

  it_boot_loader #(
    .XLEN      (32),
    .MEM_BASE  (TB_BASE),
    .MEM_DEPTH (TB_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .boot_start (boot_start),
    .write_flag (write_flag),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_size (write_size),
    .cpu_hold   (cpu_hold),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  int nvec = 0;
  int nerr = 0;

  logic [31:0] frame_words[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          mode;      // 0 always valid, 1 toggling, 2 random gaps
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 ({tag, "_write_flag"}, write_flag, 1'b0);
    chk32({tag, "_write_addr"}, write_addr, TB_BASE);
    chk32({tag, "_write_data"}, write_data, 32'h0);
    chk32({tag, "_write_size"}, 32'(write_size), 32'(NO_STORE));
    chk1 ({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    chk1 ({tag, "_boot_done"}, boot_done, 1'b0);
    chk1 ({tag, "_boot_err"}, boot_err, 1'b0);
    chk1 ({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Per-cycle observation of the write port and the ready handshake.
  task automatic mon(input string tag, input bit completes, input bit over);
    if (write_flag || completes)
      chk1({tag, "_wr_strobe"}, write_flag, completes);
    if (write_flag) begin
      chk32({tag, "_wr_size"}, 32'(write_size), 32'(STORE_WORD));
      chk1({tag, "_ready_in_write"}, in_ready, 1'b0);
      if (exp_addr_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL %s_extra_write: got write 0x%08h @0x%08h, expected no write",
                 tag, write_data, write_addr);
      end else begin
        chk32({tag, "_wr_addr"}, write_addr, exp_addr_q.pop_front());
        chk32({tag, "_wr_data"}, write_data, exp_data_q.pop_front());
      end
    end else begin
      chk1({tag, "_in_ready"}, in_ready, !over);
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] n, input int mode,
                           input logic [31:0] cksum_adj, input bit exp_done, input bit exp_err);
    logic [7:0]  bytes[$];
    logic [31:0] sum, w;
    int          idx, cyc, budget, k, lat;
    bit          acc, completes, valid_n;

    valid_n = (n != 0) && (n <= TB_DEPTH);
    bytes = {};
    exp_addr_q = {};
    exp_data_q = {};
    for (int b = 0; b < 4; b++) bytes.push_back(n[8*b +: 8]);
    sum = '0;
    if (valid_n) begin
      for (int i = 0; i < int'(n); i++) begin
        w = frame_words[i];
        sum = sum + w;
        for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
        exp_addr_q.push_back(TB_BASE + 32'(4 * i));
        exp_data_q.push_back(w);
      end
    end
    if (CKSUM && (n <= TB_DEPTH)) begin
      w = sum + cksum_adj;
      for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
    end

    idx = 0;
    cyc = 0;
    budget = 8 * bytes.size() + 100;
    while (idx < bytes.size() && cyc < budget) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      boot_start = (mode == 2) && ($urandom_range(0, 15) == 0);
      in_data = bytes[idx];
      acc = in_valid && in_ready;
      step();
      cyc++;
      boot_start = 1'b0;
      completes = 1'b0;
      if (acc) begin
        completes = valid_n && (idx >= 4) && (idx < 4 + 4 * int'(n)) && ((idx - 4) % 4 == 3);
        idx++;
      end
      mon(tag, completes, idx == bytes.size());
    end
    in_valid = 1'b0;
    chk32({tag, "_bytes_accepted"}, idx, bytes.size());

    // Cycles from the final accepted byte until the terminal status shows.
    k = 1;
    while (!(boot_done || boot_err) && k < 20) begin
      step();
      mon(tag, 1'b0, 1'b1);
      k++;
    end
    lat = (valid_n && !CKSUM) ? 2 : 1;
    chk32({tag, "_status_latency"}, k, lat);
    chk1({tag, "_boot_done"}, boot_done, exp_done);
    chk1({tag, "_boot_err"}, boot_err, exp_err);
    chk1({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    chk1({tag, "_in_ready_end"}, in_ready, 1'b0);
    chk32({tag, "_writes_missing"}, exp_addr_q.size(), 0);

    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) begin
      step();
      chk1({tag, "_ignored_ready"}, in_ready, 1'b0);
      chk1({tag, "_ignored_done"}, boot_done, exp_done);
      chk1({tag, "_ignored_write"}, write_flag, 1'b0);
    end
    in_valid = 1'b0;

    boot_start = 1'b1;
    step();
    boot_start = 1'b0;
    chk1({tag, "_rearm_ready"}, in_ready, 1'b1);
    chk1({tag, "_rearm_done"}, boot_done, 1'b0);
    chk1({tag, "_rearm_err"}, boot_err, 1'b0);
    chk1({tag, "_rearm_hold"}, cpu_hold, 1'b1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pre[6];
    logic [31:0] n;
    bit          ok;

    tbl[0] = '{32'd2,          32'h0000_0013, 32'h0010_0093, 0, 1'b1, 1'b0};
    tbl[1] = '{32'd0,          32'h0,         32'h0,         0, 1'b1, 1'b0};
    tbl[2] = '{32'd1025,       32'h0,         32'h0,         0, 1'b0, 1'b1};
    tbl[3] = '{32'd1,          32'hDEAD_BEEF, 32'h0,         1, 1'b1, 1'b0};
    tbl[4] = '{32'd3,          32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b1, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF,  32'h0,         32'h0,         2, 1'b0, 1'b1};
    tbl[6] = '{32'h0001_0001,  32'h0,         32'h0,         0, 1'b0, 1'b1};
    tbl[7] = '{32'd1024,       32'hA5A5_0001, 32'h0101_0101, 0, 1'b1, 1'b0};

    // Reset values while reset is held and right after release.
    repeat (2) step();
    chk_reset_vals("in_reset");
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_reset_vals("after_reset");

    for (int i = 0; i < 8; i++) begin
      frame_words = {};
      if (tbl[i].n <= TB_DEPTH)
        for (int j = 0; j < int'(tbl[i].n); j++)
          frame_words.push_back(j == 0 ? tbl[i].w0 :
                                j == 1 ? tbl[i].w1 : tbl[i].w0 + tbl[i].w1 * 32'(j));
      run_frame($sformatf("vec%0d", i), tbl[i].n, tbl[i].mode, 32'h0,
                tbl[i].exp_done, tbl[i].exp_err);
    end

    // Reset in the middle of a word: partial word is dropped.
    pre[0] = 8'h01; pre[1] = 8'h00; pre[2] = 8'h00; pre[3] = 8'h00;
    pre[4] = 8'hAA; pre[5] = 8'hBB;
    in_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      in_data = pre[b];
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("midrst_async");
    step();
    chk_reset_vals("midrst_held");
    @(negedge clk);
    rst = 1'b1;
    step();
    frame_words = {32'h0000_0297};
    run_frame("midrst_recover", 32'd1, 0, 32'h0, 1'b1, 1'b0);

`ifdef IT_BOOT_CKSUM_EN
    frame_words = {32'h1, 32'h2};
    run_frame("cksum_ok", 32'd2, 0, 32'h0, 1'b1, 1'b0);
    frame_words = {32'h1, 32'h2};
    run_frame("cksum_bad", 32'd2, 0, 32'h1, 1'b0, 1'b1);
`endif

    // Randomized frames against the frame-level reference.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 4) == 0) n = TB_DEPTH + $urandom_range(1, 100);
      else n = $urandom_range(0, 8);
      frame_words = {};
      if (n <= TB_DEPTH)
        for (int j = 0; j < int'(n); j++) frame_words.push_back($urandom);
      ok = (n <= TB_DEPTH);
      run_frame($sformatf("rnd%0d", r), n, 2, 32'h0, ok, !ok);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/it_boot_loader.md
Name: it_boot_loader

Overview:
- Write-side counterpart of instruction fetch: fills instruction RAM (IT RAM) from an external byte stream (UART/debug bridge), then releases the core.
- Sits between the host byte source and the IT RAM write port (write_flag/write_addr/write_data/write_size).
- Holds the core stalled via cpu_hold until the image is complete.

Parameters:
- XLEN, 32, address/data width.
- MEM_BASE, 32'h0000_0000, IT RAM base address; matches the boot fetch address.
- MEM_DEPTH, 1024, IT RAM capacity in 32-bit words.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts byte; transfer when in_valid&in_ready at posedge.
- boot_start  input  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
- write_flag  output  1  IT RAM write strobe, one cycle per word.
- write_addr  output  XLEN  byte address = MEM_BASE + 4*word_idx.
- write_data  output  32  assembled word.
- write_size  output  2  STORE_WORD while write_flag=1, else NO_STORE.
- cpu_hold  output  1  core stall/hold; 1 until DONE.
- boot_done  output  1  image loaded OK.
- boot_err  output  1  sticky error.

Behaviour:
- Frame format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte -> [7:0]).
- FSM states: LEN, DATA, WRITE, DONE, ERROR; reset state is LEN.
- Reset values: write_flag=0, write_addr=MEM_BASE, write_data=0, write_size=NO_STORE, cpu_hold=1, boot_done=0, boot_err=0. Byte counter, word index and N are cleared.
- in_ready is 1 only in LEN and DATA, so in_ready=1 immediately after reset.
- LEN:
  - Shift in 4 bytes.
  - On the 4th byte: N==0 -> DONE; N>MEM_DEPTH -> ERROR; otherwise -> DATA.
- DATA:
  - Shift bytes into a 32-bit assembly register.
  - On the 4th byte -> WRITE. The byte counter wraps 3->0.
- WRITE (exactly one cycle; in_ready=0):
  - write_flag=1, write_size=STORE_WORD, write_addr=MEM_BASE+{word_idx,2'b00}, write_data=assembled word.
  - word_idx increments.
  - If word_idx+1==N -> DONE, else -> DATA.
- Latency: the write strobe appears on the cycle after the 4th byte is accepted.
- Throughput: one word per 5 cycles at best.
- DONE: cpu_hold=0 and boot_done=1 from the first DONE cycle. in_ready=0; further bytes are ignored (not accepted).
- ERROR: cpu_hold=1, boot_err=1, in_ready=0.
- boot_start:
  - In DONE/ERROR: go to LEN, clear counters, boot_done and boot_err; set cpu_hold=1 in the same edge.
  - In LEN/DATA/WRITE: ignored.
- in_valid low mid-word: assembly and counters hold indefinitely; no timeout.
- Reset mid-frame: the partial word is discarded, no write is issued, return to LEN. Words already written stay in RAM.
- word_idx is log2(MEM_DEPTH)+1 bits; the address never exceeds MEM_BASE+4*(MEM_DEPTH-1) because of the N check.

Optional Feature:
- Macro: IT_BOOT_CKSUM_EN.
- Defined:
  - After the last WRITE, go to a CKSUM state accepting 4 more bytes (LE).
  - Compare against the 32-bit modular sum of all N data words (computed on the fly; the word count is excluded).
  - Match -> DONE; mismatch -> ERROR.
  - N==0 still reads the checksum (expected 0).
- Undefined: no CKSUM state; behaviour exactly as above.

Decomposition:
- Shared config package holds XLEN, STORE_WORD/NO_STORE write_size encodings, BOOT_IT_ADDR (MEM_BASE source) and IT_RAM_DEPTH.
- FSM state encodings stay local.
- One sub-module is natural: it_byte_assembler (4-byte LE shift register + 2-bit counter with word_valid pulse), reused for the length, data and checksum fields.

Test Plan:
- Reset, stream N=2 then bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @ MEM_BASE and 0x00100093 @ MEM_BASE+4. Each write_flag lasts 1 cycle with write_size=STORE_WORD. boot_done=1 and cpu_hold=0 the cycle after the 2nd write.
- N=0 -> DONE after 4 bytes, no write_flag; with IT_BOOT_CKSUM_EN it waits for a 4-byte zero checksum first.
- N=MEM_DEPTH+1 (1025) -> ERROR, boot_err=1, in_ready=0, no writes. boot_start pulse -> LEN, boot_err=0, in_ready=1.
- in_valid toggled 1/0 every cycle during N=1 -> same single write, data correct; no byte is accepted while in WRITE.
- rst asserted after 2 data bytes, then a full N=1 frame -> only the new word is written at MEM_BASE; outputs match reset values during rst.
- IT_BOOT_CKSUM_EN, N=2 words 0x1 and 0x2: checksum 0x3 -> DONE; checksum 0x4 -> ERROR with cpu_hold=1.
